// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master and the single-port SRAM slave.
// Signal names follow the AHB slave-side naming used on the decoder.
interface ahb_sram_slave_if;
  logic        HSEL_S;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA_S;
  logic        HREADY_S;
  logic [1:0]  HRESP_S;

  modport slave (
    input  HSEL_S, HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HRDATA_S, HREADY_S, HRESP_S
  );

  modport master (
    output HSEL_S, HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HRDATA_S, HREADY_S, HRESP_S
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: single-port word array, byte/half/word writes, configurable
// wait states, two-cycle ERROR response and read-after-write forwarding.
module ahb_sram_slave #(
  parameter int WORD_AW     = 14,
  parameter int WAIT_STATES = 0
) (
  input logic          clk,
  input logic          rst,
  ahb_sram_slave_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  state_t               r_state, w_state_nxt;
  logic [3:0]           r_wait_cnt, w_wait_cnt_nxt;
  logic                 r_wr_pend;
  logic [WORD_AW-1:0]   r_wr_addr;
  logic [3:0]           r_wr_lanes;
  logic [31:0]          r_hrdata;
  logic [31:0]          r_mem [2**WORD_AW];

  logic                 w_ready, w_accept, w_legal, w_commit;
  logic [3:0]           w_lanes;
  logic [WORD_AW-1:0]   w_word;
  logic [31:0]          w_rd_word;
  logic                 w_unused;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = lanes[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return res;
  endfunction

  assign w_ready  = (r_state == S_IDLE) || (r_state == S_ERR2);
  assign w_accept = bus.HSEL_S & bus.HREADY & bus.HTRANS[1] & w_ready;
  assign w_word   = bus.HADDR[WORD_AW+1:2];
  // Upper-bit check keeps out-of-window addresses from aliasing into the array.
  assign w_legal  = (bus.HSIZE <= 3'd2)
                  && !(bus.HSIZE == 3'd1 && bus.HADDR[0])
                  && !(bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00)
                  && ((bus.HADDR >> (WORD_AW + 2)) == 32'd0);
  assign w_commit = r_wr_pend && (r_state == S_IDLE) && !rst;
  assign w_unused = ^{bus.HBURST, bus.HTRANS[0]};

  always_comb begin
    unique case (bus.HSIZE)
      3'd0:    w_lanes = 4'b0001 << bus.HADDR[1:0];
      3'd1:    w_lanes = 4'b0011 << bus.HADDR[1:0];
      default: w_lanes = 4'b1111;
    endcase
  end

  // A read accepted on the edge that commits a write to the same word sees the new bytes.
  always_comb begin
    w_rd_word = r_mem[w_word];
    if (w_commit && (r_wr_addr == w_word))
      w_rd_word = merge_lanes(r_mem[w_word], bus.HWDATA, r_wr_lanes);
  end

  // NOTE: every output and next-state signal gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    bus.HREADY_S   = 1'b1;
    bus.HRESP_S    = RESP_OKAY;
    unique case (r_state)
      S_IDLE, S_ERR2: begin
        if (r_state == S_ERR2) begin
          bus.HRESP_S = RESP_ERROR;
          w_state_nxt = S_IDLE;
        end
        if (w_accept) begin
          if (!w_legal) begin
            w_state_nxt = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_nxt    = S_WAIT;
            w_wait_cnt_nxt = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        bus.HREADY_S   = 1'b0;
        w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        if (r_wait_cnt == 4'd1) w_state_nxt = S_IDLE;
      end
      S_ERR1: begin
        bus.HREADY_S = 1'b0;
        bus.HRESP_S  = RESP_ERROR;
        w_state_nxt  = S_ERR2;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_wr_pend  <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_lanes <= 4'd0;
      r_hrdata   <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_commit) r_wr_pend <= 1'b0;
      if (w_accept && w_legal) begin
        if (bus.HWRITE) begin
          r_wr_pend  <= 1'b1;
          r_wr_addr  <= w_word;
          r_wr_lanes <= w_lanes;
        end else begin
          r_hrdata   <= w_rd_word;
        end
      end
    end
  end

  // NOTE: the storage array carries no reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (w_commit)
      r_mem[r_wr_addr] <= merge_lanes(r_mem[r_wr_addr], bus.HWDATA, r_wr_lanes);
  end

  assign bus.HRDATA_S = r_hrdata;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: zero-wait and three-wait instances, directed transfers,
// expectations queued at issue and checked by a monitor at each data-phase completion.
module tb_ahb_sram_slave;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          err;
    int          waits;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        t_rst   [2];
  logic        t_sel   [2];
  logic [1:0]  t_trans [2];
  logic [31:0] t_addr  [2];
  logic        t_wr    [2];
  logic [2:0]  t_size  [2];
  logic [31:0] t_wdata [2];
  logic        o_rdy   [2];
  logic [1:0]  o_resp  [2];
  logic [31:0] o_rdata [2];

  ahb_sram_slave_if bus0 ();
  ahb_sram_slave_if bus1 ();

  ahb_sram_slave #(.WORD_AW(14), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(t_rst[0]), .bus(bus0.slave));
  ahb_sram_slave #(.WORD_AW(14), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rst(t_rst[1]), .bus(bus1.slave));

  assign bus0.HSEL_S = t_sel[0];   assign bus1.HSEL_S = t_sel[1];
  assign bus0.HTRANS = t_trans[0]; assign bus1.HTRANS = t_trans[1];
  assign bus0.HADDR  = t_addr[0];  assign bus1.HADDR  = t_addr[1];
  assign bus0.HWRITE = t_wr[0];    assign bus1.HWRITE = t_wr[1];
  assign bus0.HSIZE  = t_size[0];  assign bus1.HSIZE  = t_size[1];
  assign bus0.HBURST = 3'd0;       assign bus1.HBURST = 3'd0;
  assign bus0.HWDATA = t_wdata[0]; assign bus1.HWDATA = t_wdata[1];
  assign bus0.HREADY = bus0.HREADY_S;
  assign bus1.HREADY = bus1.HREADY_S;
  assign o_rdy[0]   = bus0.HREADY_S; assign o_rdy[1]   = bus1.HREADY_S;
  assign o_resp[0]  = bus0.HRESP_S;  assign o_resp[1]  = bus1.HRESP_S;
  assign o_rdata[0] = bus0.HRDATA_S; assign o_rdata[1] = bus1.HRDATA_S;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb0 [$];
  exp_t sb1 [$];
  bit   m_active [2];
  int   m_low    [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Monitor: tracks data phases from bus activity and checks each completion.
  task automatic mon_step(input int d);
    exp_t e;
    if (t_rst[d]) begin
      m_active[d] = 1'b0;
      m_low[d]    = 0;
      return;
    end
    if (m_active[d]) begin
      if (!o_rdy[d]) begin
        m_low[d]++;
      end else begin
        m_active[d] = 1'b0;
        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
          n_vec++;
          n_err++;
          $display("FAIL dut%0d unexpected completion: got response %h expected none", d, o_resp[d]);
        end else begin
          e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
          check($sformatf("dut%0d resp", d), {30'd0, o_resp[d]}, e.err ? 32'd1 : 32'd0);
          check($sformatf("dut%0d wait_cycles", d), m_low[d], e.waits);
          if (e.rd && !e.err) check($sformatf("dut%0d rdata", d), o_rdata[d], e.data);
        end
      end
    end
    if (t_sel[d] && o_rdy[d] && t_trans[d][1]) begin
      m_active[d] = 1'b1;
      m_low[d]    = 0;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon_step(d);
  end

  // Drive an address phase, hold it until accepted, then present write data.
  task automatic ap(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                    input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err,
                    input bit push = 1'b1);
    exp_t e;
    bit   rdy;
    int   n;
    t_sel[d] = 1'b1; t_trans[d] = 2'b10; t_addr[d] = addr; t_wr[d] = wr; t_size[d] = size;
    n = 0;
    do begin
      @(negedge clk); rdy = o_rdy[d];
      @(posedge clk); #1; n++;
    end while (!rdy && n < 64);
    if (!rdy) check($sformatf("dut%0d accept_timeout", d), 32'd0, 32'd1);
    if (wr) t_wdata[d] = wdata;
    if (push) begin
      e.rd = !wr; e.data = exp_rd; e.err = exp_err;
      e.waits = exp_err ? 1 : ((d == 1) ? 3 : 0);
      push_exp(d, e);
    end
  endtask

  task automatic idle(input int d);
    bit rdy;
    int n;
    t_sel[d] = 1'b0; t_trans[d] = 2'b00;
    n = 0;
    do begin
      @(negedge clk); rdy = o_rdy[d];
      @(posedge clk); #1; n++;
    end while (!rdy && n < 64);
    if (!rdy) check($sformatf("dut%0d idle_timeout", d), 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] src_pat(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0101_0111;
  endfunction

  task automatic check_reset_vals(input int d);
    check($sformatf("dut%0d reset hready", d), {31'd0, o_rdy[d]}, 32'd1);
    check($sformatf("dut%0d reset hresp", d), {30'd0, o_resp[d]}, 32'd0);
    check($sformatf("dut%0d reset hrdata", d), o_rdata[d], 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    for (int d = 0; d < 2; d++) begin
      t_rst[d] = 1'b1; t_sel[d] = 1'b0; t_trans[d] = 2'b00; t_addr[d] = 32'd0;
      t_wr[d] = 1'b0; t_size[d] = 3'd2; t_wdata[d] = 32'd0;
      m_active[d] = 1'b0; m_low[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    t_rst[0] = 1'b0; t_rst[1] = 1'b0;
    check_reset_vals(0);
    check_reset_vals(1);

    // Zero-wait instance.
    ap(0, 1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 0); idle(0);
    ap(0, 0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 0); idle(0);
    ap(0, 1, 32'h11, 3'd0, 32'h0000_AA00, 32'h0, 0);
    ap(0, 1, 32'h12, 3'd1, 32'h5566_0000, 32'h0, 0);
    ap(0, 0, 32'h10, 3'd2, 32'h0, 32'h5566AAEF, 0); idle(0);
    ap(0, 1, 32'h20, 3'd2, 32'h12345678, 32'h0, 0);
    ap(0, 0, 32'h20, 3'd2, 32'h0, 32'h12345678, 0); idle(0);
    ap(0, 0, 32'h02, 3'd2, 32'h0, 32'h0, 1); idle(0);
    ap(0, 1, 32'h12, 3'd2, 32'hFFFF_FFFF, 32'h0, 1);
    ap(0, 0, 32'h10, 3'd2, 32'h0, 32'h5566AAEF, 0); idle(0);
    ap(0, 1, 32'h11, 3'd1, 32'hFFFF_FFFF, 32'h0, 1); idle(0);
    ap(0, 1, 32'h30, 3'd3, 32'hFFFF_FFFF, 32'h0, 1); idle(0);
    ap(0, 1, 32'h00, 3'd2, 32'hCAFEF00D, 32'h0, 0);
    ap(0, 1, 32'h0001_0000, 3'd2, 32'hBADBAD00, 32'h0, 1);
    ap(0, 0, 32'h0001_0000, 3'd2, 32'h0, 32'h0, 1);
    ap(0, 0, 32'h00, 3'd2, 32'h0, 32'hCAFEF00D, 0);
    ap(0, 0, 32'h13, 3'd0, 32'h0, 32'h5566AAEF, 0);
    ap(0, 0, 32'h10, 3'd2, 32'h0, 32'h5566AAEF, 0); idle(0);

    // Three-wait instance: fill source, copy via readback, verify destination.
    for (int i = 0; i < 16; i++)
      ap(1, 1, 32'h100 + 32'(4 * i), 3'd2, src_pat(i), 32'h0, 0);
    idle(1);
    for (int i = 0; i < 16; i++) begin
      ap(1, 0, 32'h100 + 32'(4 * i), 3'd2, 32'h0, src_pat(i), 0); idle(1);
      v = o_rdata[1];
      ap(1, 1, 32'h200 + 32'(4 * i), 3'd2, v, 32'h0, 0); idle(1);
    end
    for (int i = 0; i < 16; i++)
      ap(1, 0, 32'h200 + 32'(4 * i), 3'd2, 32'h0, src_pat(i), 0);
    idle(1);
    ap(1, 1, 32'h300, 3'd2, 32'h0BADF00D, 32'h0, 0);
    ap(1, 0, 32'h300, 3'd2, 32'h0, 32'h0BADF00D, 0); idle(1);
    ap(1, 0, 32'h301, 3'd2, 32'h0, 32'h0, 1); idle(1);

    // Reset while a write sits in its wait states: write must be dropped.
    ap(1, 1, 32'h40, 3'd2, 32'h1111_1111, 32'h0, 0); idle(1);
    ap(1, 1, 32'h40, 3'd2, 32'h2222_2222, 32'h0, 0, 1'b0);
    t_sel[1] = 1'b0; t_trans[1] = 2'b00;
    @(posedge clk); #1;
    t_rst[1] = 1'b1;
    @(posedge clk); #1;
    t_rst[1] = 1'b0;
    check_reset_vals(1);
    ap(1, 0, 32'h40, 3'd2, 32'h0, 32'h1111_1111, 0); idle(1);

    repeat (2) @(posedge clk);
    check("dut0 scoreboard drained", sb0.size(), 32'd0);
    check("dut1 scoreboard drained", sb1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
